// File: rtl/regfile_pkg.sv
// Shared constants and types for the regfile_sb register file / scoreboard slice.
package regfile_pkg;

    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_NUM_READ   = 2;
    localparam int unsigned RF_ZERO_IDX   = 0;

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

endpackage : regfile_pkg

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of regfile_sb; master drives requests, slave (the register file) answers.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned NUM_READ   = RF_NUM_READ
);

    logic                           wen;
    logic [ADDR_WIDTH-1:0]          waddr;
    logic [DATA_WIDTH-1:0]          wdata;
    logic [NUM_READ*ADDR_WIDTH-1:0] raddr;
    logic [NUM_READ*DATA_WIDTH-1:0] rdata;
    logic [NUM_READ-1:0]            rbusy;
    logic                           issue_valid;
    logic [ADDR_WIDTH-1:0]          issue_addr;
    logic                           issue_stall;
    logic [ADDR_WIDTH:0]            busy_count;

    modport master (
        output wen, waddr, wdata, raddr, issue_valid, issue_addr,
        input  rdata, rbusy, issue_stall, busy_count
    );

    modport slave (
        input  wen, waddr, wdata, raddr, issue_valid, issue_addr,
        output rdata, rbusy, issue_stall, busy_count
    );

endinterface : regfile_sb_if

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks pending destinations, flags WAW issue stalls, counts busy registers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen_i,
    input  logic [ADDR_WIDTH-1:0]    waddr_i,
    input  logic                     issue_valid_i,
    input  logic [ADDR_WIDTH-1:0]    issue_addr_i,
    output logic [2**ADDR_WIDTH-1:0] busy_o,
    output logic                     issue_stall_c_o,
    output logic [ADDR_WIDTH:0]      busy_count_o
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(RF_ZERO_IDX);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_hit, iss_req, stall, set, clr;

    // A same-cycle writeback to the issued register retires the old producer, so no stall;
    // the set is applied after the clear so the new producer keeps the register busy.
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        wr_hit  = wen_i && (waddr_i != ZERO_IDX);
        iss_req = issue_valid_i && (issue_addr_i != ZERO_IDX);
        stall   = iss_req && busy_q[issue_addr_i] && !(wen_i && (waddr_i == issue_addr_i));
        set     = iss_req && !stall;
        clr     = wr_hit && busy_q[waddr_i];
        if (wr_hit) begin
            busy_d[waddr_i] = 1'b0;
        end
        if (set) begin
            busy_d[issue_addr_i] = 1'b1;
        end
        count_d = count_q + CW'(set) - CW'(clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o          = busy_q;
    assign issue_stall_c_o = stall;
    assign busy_count_o    = count_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// Multi-read-port register file (r0 hardwired to zero) with integrated busy scoreboard.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned NUM_READ   = RF_NUM_READ
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(RF_ZERO_IDX);

    logic [DATA_WIDTH-1:0] rf_q [DEPTH];
    logic [DATA_WIDTH-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic                  wr_en;

    assign wr_en = bus.wen && (bus.waddr != ZERO_IDX);

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk             (clk),
        .rst             (rst),
        .wen_i           (bus.wen),
        .waddr_i         (bus.waddr),
        .issue_valid_i   (bus.issue_valid),
        .issue_addr_i    (bus.issue_addr),
        .busy_o          (busy),
        .issue_stall_c_o (bus.issue_stall),
        .busy_count_o    (bus.busy_count)
    );

    always_comb begin
        rf_d = rf_q;
        if (wr_en) begin
            rf_d[bus.waddr] = bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q <= '{default: '0};
        end else begin
            rf_q <= rf_d;
        end
    end

    // Independent combinational read ports.
    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd_c;
        logic                  rb_c;

        assign ra = bus.raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd_c = rf_q[ra];
            rb_c = busy[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (bus.waddr == ra)) begin
                rd_c = bus.wdata;
                rb_c = 1'b0;
            end
`endif
            if (ra == ZERO_IDX) begin
                rd_c = '0;
                rb_c = 1'b0;
            end
        end

        assign bus.rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd_c;
        assign bus.rbusy[k]                          = rb_c;
    end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic vs. a reference model.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int unsigned AW    = RF_ADDR_WIDTH;
    localparam int unsigned DW    = RF_DATA_WIDTH;
    localparam int unsigned NR    = RF_NUM_READ;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) bus ();

    regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_rf   [DEPTH];
    bit            m_busy [DEPTH];

    logic          cur_rst, cur_we, cur_iv;
    rf_addr_t      cur_wa, cur_ra0, cur_ra1, cur_ia;
    logic [DW-1:0] cur_wd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t got=0x%0h exp=0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        foreach (m_busy[i]) n += int'(m_busy[i]);
        return n;
    endfunction

    // Expected read result for one port, straight from the read rules.
    task automatic model_read(input rf_addr_t ra, output logic [DW-1:0] d, output logic b);
        if (ra == 0) begin
            d = '0;
            b = 1'b0;
        end else begin
            d = m_rf[ra];
            b = m_busy[ra];
`ifdef REGFILE_BYPASS_EN
            if (cur_we && cur_wa == ra) begin
                d = cur_wd;
                b = 1'b0;
            end
`endif
        end
    endtask

    function automatic logic model_stall();
        return cur_iv && (cur_ia != 0) && m_busy[cur_ia] && !(cur_we && cur_wa == cur_ia);
    endfunction

    task automatic compare_model();
        logic [DW-1:0] ed;
        logic          eb;
        model_read(cur_ra0, ed, eb);
        check_eq("rdata0", 64'(bus.rdata[DW-1:0]), 64'(ed));
        check_eq("rbusy0", 64'(bus.rbusy[0]), 64'(eb));
        model_read(cur_ra1, ed, eb);
        check_eq("rdata1", 64'(bus.rdata[2*DW-1:DW]), 64'(ed));
        check_eq("rbusy1", 64'(bus.rbusy[1]), 64'(eb));
        check_eq("issue_stall", 64'(bus.issue_stall), 64'(model_stall()));
        check_eq("busy_count", 64'(bus.busy_count), 64'(model_count()));
    endtask

    task automatic update_model();
        logic st;
        st = model_stall();
        if (cur_rst) begin
            foreach (m_rf[i]) begin
                m_rf[i]   = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (cur_we && cur_wa != 0) begin
                m_rf[cur_wa]   = cur_wd;
                m_busy[cur_wa] = 1'b0;
            end
            if (cur_iv && cur_ia != 0 && !st) m_busy[cur_ia] = 1'b1;
        end
    endtask

    // Drive one cycle's inputs after the falling edge and compare combinational outputs.
    task automatic apply(input logic r, input logic we, input rf_addr_t wa, input logic [DW-1:0] wd,
                         input rf_addr_t ra0, input rf_addr_t ra1, input logic iv, input rf_addr_t ia);
        @(negedge clk);
        cur_rst = r;  cur_we = we; cur_wa = wa; cur_wd = wd;
        cur_ra0 = ra0; cur_ra1 = ra1; cur_iv = iv; cur_ia = ia;
        rst             = r;
        bus.wen         = we;
        bus.waddr       = wa;
        bus.wdata       = wd;
        bus.raddr       = {ra1, ra0};
        bus.issue_valid = iv;
        bus.issue_addr  = ia;
        #1;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        update_model();
    endtask

    task automatic idle(input rf_addr_t ra0, input rf_addr_t ra1);
        apply(1'b0, 1'b0, '0, '0, ra0, ra1, 1'b0, '0);
    endtask

    function automatic rf_addr_t pick();
        if ($urandom_range(1) == 0) return rf_addr_t'($urandom_range(7));
        return rf_addr_t'($urandom_range(DEPTH - 1));
    endfunction

    initial begin
        foreach (m_rf[i]) begin
            m_rf[i]   = '0;
            m_busy[i] = 1'b0;
        end
        rst = 1'b1;
        bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
        bus.issue_valid = 1'b0; bus.issue_addr = '0;

        // Reset state
        apply(1'b1, 1'b0, '0, '0, 5'd0, 5'd0, 1'b0, '0); tick();
        idle(5'd1, 5'd31);
        check_eq("rst_count", 64'(bus.busy_count), 64'd0);
        check_eq("rst_r1", 64'(bus.rdata[DW-1:0]), 64'd0);
        tick();

        // r0 is hardwired to zero
        apply(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, '0); tick();
        idle(5'd0, 5'd0);
        check_eq("r0_port0", 64'(bus.rdata[DW-1:0]), 64'd0);
        check_eq("r0_port1", 64'(bus.rdata[2*DW-1:DW]), 64'd0);
        check_eq("r0_busy", 64'(bus.rbusy), 64'd0);
        tick();

        // Reset clears written data
        apply(1'b0, 1'b1, 5'd5, 32'h11, 5'd5, 5'd5, 1'b0, '0); tick();
        idle(5'd5, 5'd0);
        check_eq("r5_written", 64'(bus.rdata[DW-1:0]), 64'h11);
        tick();
        apply(1'b1, 1'b1, 5'd6, 32'h66, 5'd5, 5'd0, 1'b1, 5'd8); tick();
        idle(5'd5, 5'd6);
        check_eq("r5_after_rst", 64'(bus.rdata[DW-1:0]), 64'd0);
        check_eq("r6_rst_override", 64'(bus.rdata[2*DW-1:DW]), 64'd0);
        check_eq("count_after_rst", 64'(bus.busy_count), 64'd0);
        tick();

        // Issue, WAW stall, writeback
        apply(1'b0, 1'b0, '0, '0, 5'd7, 5'd0, 1'b1, 5'd7); tick();
        apply(1'b0, 1'b0, '0, '0, 5'd7, 5'd7, 1'b1, 5'd7);
        check_eq("r7_busy", 64'(bus.rbusy[0]), 64'd1);
        check_eq("r7_count", 64'(bus.busy_count), 64'd1);
        check_eq("r7_waw_stall", 64'(bus.issue_stall), 64'd1);
        tick();
        idle(5'd7, 5'd0);
        check_eq("r7_count_hold", 64'(bus.busy_count), 64'd1);
        tick();
        apply(1'b0, 1'b1, 5'd7, 32'h1234, 5'd7, 5'd0, 1'b0, '0); tick();
        idle(5'd7, 5'd7);
        check_eq("r7_wb_busy", 64'(bus.rbusy[0]), 64'd0);
        check_eq("r7_wb_data", 64'(bus.rdata[DW-1:0]), 64'h1234);
        check_eq("r7_wb_count", 64'(bus.busy_count), 64'd0);
        tick();

        // Same-cycle issue and writeback to the same register
        apply(1'b0, 1'b0, '0, '0, 5'd9, 5'd0, 1'b1, 5'd9); tick();
        apply(1'b0, 1'b1, 5'd9, 32'h55, 5'd9, 5'd0, 1'b1, 5'd9);
        check_eq("coll_stall", 64'(bus.issue_stall), 64'd0);
        tick();
        idle(5'd9, 5'd0);
        check_eq("coll_data", 64'(bus.rdata[DW-1:0]), 64'h55);
        check_eq("coll_busy", 64'(bus.rbusy[0]), 64'd1);
        check_eq("coll_count", 64'(bus.busy_count), 64'd1);
        tick();
        apply(1'b0, 1'b1, 5'd9, 32'h56, 5'd0, 5'd0, 1'b0, '0); tick();

        // Write-to-read forwarding
        apply(1'b0, 1'b1, 5'd3, 32'h77, 5'd0, 5'd0, 1'b0, '0); tick();
        apply(1'b0, 1'b1, 5'd3, 32'hA5A5, 5'd0, 5'd3, 1'b0, '0);
`ifdef REGFILE_BYPASS_EN
        check_eq("bypass_data", 64'(bus.rdata[2*DW-1:DW]), 64'hA5A5);
`else
        check_eq("nobypass_data", 64'(bus.rdata[2*DW-1:DW]), 64'h77);
`endif
        check_eq("bypass_busy", 64'(bus.rbusy[1]), 64'd0);
        tick();
        idle(5'd0, 5'd3);
        check_eq("r3_next", 64'(bus.rdata[2*DW-1:DW]), 64'hA5A5);
        tick();

        // Fill the scoreboard, then drain it
        for (int i = 1; i < int'(DEPTH); i++) begin
            apply(1'b0, 1'b0, '0, '0, rf_addr_t'(i), 5'd0, 1'b1, rf_addr_t'(i)); tick();
        end
        apply(1'b0, 1'b1, 5'd0, 32'hFFFF, 5'd31, 5'd1, 1'b0, '0);
        check_eq("full_count", 64'(bus.busy_count), 64'(DEPTH - 1));
        tick();
        idle(5'd31, 5'd1);
        check_eq("full_r0_wb", 64'(bus.busy_count), 64'(DEPTH - 1));
        tick();
        for (int i = 1; i < int'(DEPTH); i++) begin
            apply(1'b0, 1'b1, rf_addr_t'(i), DW'(i * 3), 5'd0, rf_addr_t'(i), 1'b0, '0); tick();
        end
        idle(5'd31, 5'd1);
        check_eq("drained_count", 64'(bus.busy_count), 64'd0);
        check_eq("drained_r31", 64'(bus.rdata[DW-1:0]), 64'd93);
        tick();

        // Randomized concurrent traffic
        for (int n = 0; n < 10000; n++) begin
            logic     r, we, iv;
            rf_addr_t wa, ra0, ra1, ia;
            r   = ($urandom_range(511) == 0);
            we  = 1'($urandom_range(1));
            iv  = 1'($urandom_range(1));
            wa  = pick();
            ia  = ($urandom_range(3) == 0) ? wa : pick();
            ra0 = ($urandom_range(3) == 0) ? wa : pick();
            ra1 = ($urandom_range(3) == 0) ? ra0 : pick();
            apply(r, we, wa, DW'($urandom()), ra0, ra1, iv, ia);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port general-purpose register file with an integrated busy-bit scoreboard, for the in-order core's decode/writeback stages.
- Register 0 is hardwired to zero.
- Decode issues a destination register; that register is marked busy until writeback clears it.
- Read ports report data plus a busy flag so decode can stall on RAW hazards.

Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.
- NUM_READ, 2, number of independent combinational read ports (1..4).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- wen  input  1  writeback write enable.
- waddr  input  ADDR_WIDTH  writeback destination index.
- wdata  input  DATA_WIDTH  writeback data.
- raddr  input  NUM_READ*ADDR_WIDTH  packed read indices; port k is bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  output  NUM_READ*DATA_WIDTH  packed read data, same packing.
- rbusy  output  NUM_READ  busy flag of each read port's register.
- issue_valid  input  1  decode claims issue_addr as a pending destination.
- issue_addr  input  ADDR_WIDTH  destination being claimed.
- issue_stall  output  1  issue_addr already busy (WAW); the issue is ignored.
- busy_count  output  ADDR_WIDTH+1  number of registers currently busy.

Behaviour:
- Reset: clk and rst are fixed as named. rst is synchronous and active-high; the clock is single.
  - On rst high at a posedge: all registers clear to 0, all busy bits clear, busy_count = 0.
  - rst overrides any wen or issue_valid in the same cycle.
  - A pending writeback arriving after rst is written normally. The busy bit stays 0.
- Write:
  - On posedge with wen=1 and waddr!=0: rf[waddr] <= wdata and busy[waddr] <= 0.
  - wen with waddr=0 is dropped.
- Read:
  - Combinational, zero latency.
  - raddr=0 gives rdata=0 and rbusy=0.
  - Otherwise rdata = rf[raddr], rbusy = busy[raddr], subject to bypass (Optional Feature).
- Issue:
  - issue_stall = issue_valid & (issue_addr!=0) & busy[issue_addr] & ~(wen & waddr==issue_addr).
  - On posedge with issue_valid=1, issue_stall=0 and issue_addr!=0: busy[issue_addr] <= 1.
  - issue_addr=0 never sets busy and never stalls.
- Simultaneous writeback and issue to the same register X:
  - Data is written.
  - Busy ends at 1: set wins, because the new producer supersedes.
  - issue_stall = 0.
- Simultaneous writeback and issue to different registers: both take effect.
- busy_count:
  - Registered.
  - Next value = current + (set ? 1 : 0) - (clear of a busy register ? 1 : 0).
  - Never wraps; maximum 2**ADDR_WIDTH-1.
  - Writeback to a non-busy register does not decrement.
- Read ports are independent. Duplicate raddr values across ports return identical results.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port with raddr==waddr!=0 while wen=1 returns rdata=wdata and rbusy=0 in the same cycle (write-to-read forwarding).
- Undefined: the read returns the old rf value and the current busy bit. The new value is visible from the next cycle.

Decomposition:
- Shared package regfile_pkg:
  - default constants RF_ADDR_WIDTH=5, RF_DATA_WIDTH=32, RF_NUM_READ=2;
  - localparam RF_ZERO_IDX=0;
  - typedef rf_addr_t.
- One natural sub-module, regfile_scoreboard: holds the busy vector, issue_stall logic and busy_count. It takes wen/waddr/issue_valid/issue_addr.
- regfile_sb instantiates the scoreboard and contains the storage array and read muxes.

Test Plan (ADDR_WIDTH=5, DATA_WIDTH=32, NUM_READ=2):
- Reset/zero:
  - Write 0xDEADBEEF to r0, then read r0 on both ports -> rdata=0, rbusy=0.
  - Assert rst after writing r5=0x11 -> next cycle r5 reads 0, busy_count=0.
- Scoreboard:
  - Issue r7 -> rbusy=1 for raddr=7 and busy_count=1.
  - Second issue of r7 -> issue_stall=1 and busy_count stays 1.
  - Writeback r7=0x1234 -> next cycle rbusy=0, rdata=0x1234, busy_count=0.
- Collision: with r9 busy, drive issue r9 and writeback r9=0x55 in the same cycle -> issue_stall=0, rf[9]=0x55, r9 still busy, busy_count=1.
- Bypass:
  - Drive wen, waddr=3, wdata=0xA5A5 and raddr port1=3 in the same cycle.
  - With REGFILE_BYPASS_EN: rdata1=0xA5A5, rbusy1=0.
  - Without it: rdata1 = old value.
- Count saturation: issue all of r1..r31 -> busy_count=31. A writeback to the already-free r0 leaves 31. Then write back all 31 -> busy_count=0.
- Random multi-port reads against a reference model, 10k cycles, with concurrent issue/writeback -> zero mismatches.
